// File: rtl/cam_capture_ctrl_if.sv
// Camera byte stream and frame-buffer write port bundles for cam_capture_ctrl.
// master drives the signals, slave receives them.
interface cam_byte_if;
   logic       vsync;
   logic       href;
   logic       byte_valid;
   logic [7:0] byte_data;

   modport master (output vsync, href, byte_valid, byte_data);
   modport slave  (input  vsync, href, byte_valid, byte_data);
endinterface

interface fb_wr_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              we;
   logic [ADDR_W-1:0] wAddr;
   logic [11:0]       wData;

   modport master (output we, wAddr, wData);
   modport slave  (input  we, wAddr, wData);
endinterface

// File: rtl/cam_capture_ctrl.sv
// Write-side controller for the RGB444 frame buffer: frames the RGB565 camera
// byte stream with vsync/href, packs byte pairs into 12-bit pixels and sequences frames.
module cam_capture_ctrl #(
   parameter int unsigned H_PIX   = 320,
   parameter int unsigned V_LINES = 240,
   parameter int unsigned ADDR_W  = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cap_en,
   input  logic       single_shot,
   input  logic       err_clr,
   cam_byte_if.slave  cam,
   fb_wr_if.master    wr,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic       err_line,
   output logic       err_frame
);

   localparam int unsigned XW = $clog2(H_PIX + 1);
   localparam int unsigned YW = $clog2(V_LINES + 1);
   localparam logic [XW-1:0] X_END = XW'(H_PIX);
   localparam logic [YW-1:0] Y_END = YW'(V_LINES);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;

   logic [1:0]        state;
   logic              vsync_d, href_d;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic              y_ovf;
   logic              phase;
   logic [6:0]        hi;
   logic [ADDR_W-1:0] addr;
   logic              shot_done;

   logic vs_fall, vs_rise, href_fall;
   logic active, accept, in_frame, pix_ok;
   logic line_err_set, frame_err_set;
   logic [3:0] byte_unused;

   assign byte_unused = {cam.byte_data[6:5], cam.byte_data[3], cam.byte_data[0]};

   always_comb begin
      vs_fall       = vsync_d & ~cam.vsync;
      vs_rise       = ~vsync_d & cam.vsync;
      href_fall     = href_d & ~cam.href;
      active        = (state == S_ACTIVE);
      accept        = active & ~vs_rise & cam.href & cam.byte_valid;
      in_frame      = (y < Y_END);
      pix_ok        = in_frame & (x < X_END);
      line_err_set  = 1'b0;
      frame_err_set = 1'b0;
      if (active && !vs_rise) begin
         if (accept && phase && in_frame && !pix_ok)
            line_err_set = 1'b1;
         if (href_fall && in_frame && ((x != X_END) || phase))
            line_err_set = 1'b1;
      end
      // y saturates at V_LINES, so a surplus line is remembered in y_ovf
      if (active && vs_rise && ((y != Y_END) || y_ovf))
         frame_err_set = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         vsync_d    <= 1'b0;
         href_d     <= 1'b0;
         x          <= '0;
         y          <= '0;
         y_ovf      <= 1'b0;
         phase      <= 1'b0;
         hi         <= '0;
         addr       <= '0;
         shot_done  <= 1'b0;
         wr.we      <= 1'b0;
         wr.wAddr   <= '0;
         wr.wData   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         err_line   <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         vsync_d    <= cam.vsync;
         href_d     <= cam.href;
         wr.we      <= 1'b0;
         frame_done <= 1'b0;
         err_line   <= line_err_set | (err_line & ~err_clr);
         err_frame  <= frame_err_set | (err_frame & ~err_clr);
         if (!cap_en)
            shot_done <= 1'b0;

         case (state)
            S_IDLE: begin
               // after a single-shot frame the enable must drop before re-arming
               if (cap_en && !shot_done)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (!cap_en) begin
                  state <= S_IDLE;
               end else if (vs_fall) begin
                  state <= S_ACTIVE;
                  busy  <= 1'b1;
                  x     <= '0;
                  y     <= '0;
                  y_ovf <= 1'b0;
                  phase <= 1'b0;
                  addr  <= '0;
               end
            end
            S_ACTIVE: begin
               if (vs_rise) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  busy       <= 1'b0;
                  if (single_shot)
                     shot_done <= 1'b1;
                  state <= (single_shot || !cap_en) ? S_IDLE : S_WAIT;
               end else if (href_fall) begin
                  x     <= '0;
                  phase <= 1'b0;
                  if (in_frame)
                     y <= y + YW'(1);
                  else
                     y_ovf <= 1'b1;
               end else if (accept) begin
                  if (!phase) begin
                     hi    <= {cam.byte_data[7:4], cam.byte_data[2:0]};
                     phase <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (pix_ok) begin
                        wr.we    <= 1'b1;
                        wr.wAddr <= addr;
                        wr.wData <= {hi[6:3], hi[2:0], cam.byte_data[7], cam.byte_data[4:1]};
                        addr     <= addr + ADDR_W'(1);
                        x        <= x + XW'(1);
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed self-checking bench for cam_capture_ctrl on a reduced 8x6 geometry.
module tb_cam_capture_ctrl;

   localparam int H = 8;
   localparam int V = 6;
   localparam int AW = 6;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cap_en, single_shot, err_clr;
   logic       busy, frame_done, err_line, err_frame;
   logic [7:0] frame_cnt;

   cam_byte_if cam ();
   fb_wr_if #(.ADDR_W(AW)) wr ();

   cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cap_en     (cap_en),
      .single_shot(single_shot),
      .err_clr    (err_clr),
      .cam        (cam),
      .wr         (wr),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .err_line   (err_line),
      .err_frame  (err_frame)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // write monitor: address must count from 0 within each captured frame
   int         wr_total = 0;
   int         frame_wr = 0;
   int         addr_err = 0;
   int         fd_total = 0;
   logic [11:0] last_data = '0;
   logic       busy_q = 1'b0;

   always @(negedge clk) begin
      if (busy && !busy_q) frame_wr = 0;
      if (wr.we) begin
         if (int'(wr.wAddr) !== frame_wr) addr_err++;
         frame_wr++;
         wr_total++;
         last_data = wr.wData;
      end
      if (frame_done) fd_total++;
      busy_q = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_begin;
      cam.vsync = 1'b1;
      repeat (3) tick;
      cam.vsync = 1'b0;
      tick;
      tick;
   endtask

   task automatic frame_end(output logic fd, output logic bz);
      cam.vsync = 1'b1;
      tick;
      fd = frame_done;
      bz = busy;
      tick;
      tick;
   endtask

   task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
      cam.href = 1'b1;
      tick;
      for (int i = 0; i < nbytes; i++) begin
         cam.byte_valid = 1'b1;
         cam.byte_data  = (i % 2 == 0) ? b0 : b1;
         tick;
      end
      cam.byte_valid = 1'b0;
      cam.href = 1'b0;
      tick;
      tick;
   endtask

   task automatic send_lines(input int nlines, input int sp_line, input int sp_bytes);
      for (int l = 0; l < nlines; l++)
         send_line((l == sp_line) ? sp_bytes : 2 * H, 8'hF8, 8'h1F);
   endtask

   task automatic pulse_err_clr;
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      tick;
   endtask

   int   wr0, fd0;
   logic fd, bz;

   initial begin
      reset_n = 1'b0;
      cap_en = 1'b0;
      single_shot = 1'b0;
      err_clr = 1'b0;
      cam.vsync = 1'b0;
      cam.href = 1'b0;
      cam.byte_valid = 1'b0;
      cam.byte_data = 8'h00;
      tick;
      tick;
      check("rst_we", wr.we, 0);
      check("rst_waddr", wr.wAddr, 0);
      check("rst_wdata", wr.wData, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_err_line", err_line, 0);
      check("rst_err_frame", err_frame, 0);
      reset_n = 1'b1;
      tick;

      // frame 1: continuous, first pixel A5/C3 checked cycle by cycle
      cap_en = 1'b1;
      tick;
      tick;
      wr0 = wr_total;
      fd0 = fd_total;
      frame_begin;
      check("busy_active", busy, 1);
      cam.href = 1'b1;
      tick;
      cam.byte_valid = 1'b1;
      cam.byte_data = 8'hA5;
      tick;
      check("we_after_hi_byte", wr.we, 0);
      cam.byte_data = 8'hC3;
      tick;
      check("pack_we", wr.we, 1);
      check("pack_wdata", wr.wData, 12'hAB1);
      check("pack_waddr", wr.wAddr, 0);
      cam.byte_valid = 1'b0;
      tick;
      check("pack_we_one_cycle", wr.we, 0);
      for (int i = 0; i < 2 * (H - 1); i++) begin
         cam.byte_valid = 1'b1;
         cam.byte_data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
         tick;
      end
      cam.byte_valid = 1'b0;
      cam.href = 1'b0;
      tick;
      tick;
      send_lines(V - 1, -1, 0);
      frame_end(fd, bz);
      check("f1_frame_done", fd, 1);
      check("f1_busy_falls", bz, 0);
      check("f1_done_once", fd_total - fd0, 1);
      check("f1_frame_cnt", frame_cnt, 1);
      check("f1_writes", wr_total - wr0, H * V);
      check("f1_addr_order", addr_err, 0);
      check("f1_last_data", last_data, 12'hF0F);
      check("f1_err_line", err_line, 0);
      check("f1_err_frame", err_frame, 0);

      // frame 2: line 2 short by one pixel
      wr0 = wr_total;
      frame_begin;
      send_lines(V, 2, 2 * H - 2);
      frame_end(fd, bz);
      check("short_writes", wr_total - wr0, H * V - 1);
      check("short_err_line", err_line, 1);
      check("short_err_frame", err_frame, 0);
      check("short_addr_contig", addr_err, 0);
      check("short_frame_cnt", frame_cnt, 2);
      pulse_err_clr;
      check("short_err_clr", err_line, 0);

      // frame 3: line 1 one pixel long, one surplus line
      wr0 = wr_total;
      frame_begin;
      send_lines(V + 1, 1, 2 * H + 2);
      frame_end(fd, bz);
      check("long_writes", wr_total - wr0, H * V);
      check("long_err_line", err_line, 1);
      check("long_err_frame", err_frame, 1);
      check("long_frame_cnt", frame_cnt, 3);
      pulse_err_clr;
      check("long_clr_line", err_line, 0);
      check("long_clr_frame", err_frame, 0);

      // frame 4: vsync rises in the middle of line 3
      wr0 = wr_total;
      frame_begin;
      send_lines(3, -1, 0);
      cam.href = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         cam.byte_valid = 1'b1;
         cam.byte_data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
         tick;
      end
      cam.byte_valid = 1'b0;
      frame_end(fd, bz);
      cam.href = 1'b0;
      tick;
      check("midline_frame_done", fd, 1);
      check("midline_writes", wr_total - wr0, 3 * H + 2);
      check("midline_err_frame", err_frame, 1);
      check("midline_frame_cnt", frame_cnt, 4);
      pulse_err_clr;

      // single-shot: two frames offered, only the first captured
      single_shot = 1'b1;
      wr0 = wr_total;
      fd0 = fd_total;
      frame_begin;
      send_lines(V, -1, 0);
      frame_end(fd, bz);
      check("ss_busy_after", busy, 0);
      frame_begin;
      check("ss_idle_second", busy, 0);
      send_lines(V, -1, 0);
      frame_end(fd, bz);
      check("ss_writes", wr_total - wr0, H * V);
      check("ss_done_count", fd_total - fd0, 1);
      check("ss_frame_cnt", frame_cnt, 5);

      // asynchronous reset in the middle of a frame
      single_shot = 1'b0;
      cap_en = 1'b0;
      tick;
      cap_en = 1'b1;
      tick;
      tick;
      frame_begin;
      send_lines(2, -1, 0);
      cam.href = 1'b1;
      tick;
      for (int i = 0; i < 6; i++) begin
         cam.byte_valid = 1'b1;
         cam.byte_data = (i % 2 == 0) ? 8'hF8 : 8'h1F;
         tick;
      end
      check("pre_rst_waddr", wr.wAddr, 2 * H + 2);
      reset_n = 1'b0;
      #1;
      check("arst_waddr", wr.wAddr, 0);
      check("arst_wdata", wr.wData, 0);
      check("arst_busy", busy, 0);
      check("arst_frame_cnt", frame_cnt, 0);
      cam.byte_valid = 1'b0;
      cam.href = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;
      wr0 = wr_total;
      frame_begin;
      send_lines(V, -1, 0);
      frame_end(fd, bz);
      check("resume_writes", wr_total - wr0, H * V);
      check("resume_addr_order", addr_err, 0);
      check("resume_frame_cnt", frame_cnt, 1);
      check("resume_err_line", err_line, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
